// File: rtl/solve_ntru_mul_pipe_param_pkg.sv
// rtl/solve_ntru_mul_pipe_param_pkg.sv - shared constants and width helper for the NTRU multiplier
package solve_ntru_mul_pipe_param_pkg;

  localparam int SAT_MODE_WRAP = 0;
  localparam int SAT_MODE_SAT  = 1;

  // One extra bit covers the zero-extension of an unsigned din1.
  function automatic int prod_w(input int a, input int b);
    return a + b + 1;
  endfunction

endpackage

// File: rtl/solve_ntru_mul_pipe_param_if.sv
// rtl/solve_ntru_mul_pipe_param_if.sv - operand/result valid-ready bundle for the NTRU multiplier
interface solve_ntru_mul_pipe_param_if #(
  parameter int DIN0_WIDTH = 12,
  parameter int DIN1_WIDTH = 9,
  parameter int DOUT_WIDTH = 12
);

  logic                  in_valid;
  logic                  in_ready;
  logic [DIN0_WIDTH-1:0] din0;
  logic [DIN1_WIDTH-1:0] din1;
  logic                  out_valid;
  logic                  out_ready;
  logic [DOUT_WIDTH-1:0] dout;

  modport master (
    output in_valid, din0, din1, out_ready,
    input  in_ready, out_valid, dout
  );

  modport slave (
    input  in_valid, din0, din1, out_ready,
    output in_ready, out_valid, dout
  );

endinterface

// File: rtl/solve_ntru_mul_pipe_param_narrow.sv
// rtl/solve_ntru_mul_pipe_param_narrow.sv - combinational product narrowing, wrap or signed saturate
module solve_ntru_mul_pipe_param_narrow
  import solve_ntru_mul_pipe_param_pkg::*;
#(
  parameter int PROD_W     = 22,
  parameter int DOUT_WIDTH = 12,
  parameter int SAT_MODE   = SAT_MODE_WRAP
) (
  input  logic signed [PROD_W-1:0]     prod_i,
  output logic        [DOUT_WIDTH-1:0] dout_o
);

  // Full-width output can never overflow, so the range check folds away.
  localparam bit DO_SAT = (SAT_MODE == SAT_MODE_SAT) && (DOUT_WIDTH < PROD_W);
  localparam logic [DOUT_WIDTH-1:0] SAT_MAX = {DOUT_WIDTH{1'b1}} >> 1;
  localparam logic [DOUT_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  logic [PROD_W-DOUT_WIDTH:0] upper;
  logic                       ovf;

  assign upper = prod_i[PROD_W-1:DOUT_WIDTH-1];
  assign ovf   = DO_SAT && !((&upper) || !(|upper));

  always_comb begin
    dout_o = prod_i[DOUT_WIDTH-1:0];
    if (ovf) begin
      dout_o = prod_i[PROD_W-1] ? SAT_MIN : SAT_MAX;
    end
  end

endmodule

// File: rtl/solve_ntru_mul_pipe_param.sv
// rtl/solve_ntru_mul_pipe_param.sv - pipelined din0*din1 with global stall, ce and narrowed output
module solve_ntru_mul_pipe_param
  import solve_ntru_mul_pipe_param_pkg::*;
#(
  parameter int DIN0_WIDTH  = 12,
  parameter int DIN1_WIDTH  = 9,
  parameter int DIN1_SIGNED = 0,
  parameter int DOUT_WIDTH  = 12,
  parameter int NUM_STAGE   = 4,
  parameter int SAT_MODE    = SAT_MODE_WRAP
) (
  input logic                         clk_i,
  input logic                         reset_i,
  input logic                         ce_i,
  solve_ntru_mul_pipe_param_if.slave  bus
);

  localparam int PROD_W = prod_w(DIN0_WIDTH, DIN1_WIDTH);

  logic                         advance;
  logic [NUM_STAGE-1:0]         v_q;
  logic signed [DIN0_WIDTH-1:0] din0_q;
  logic [DIN1_WIDTH-1:0]        din1_q;
  logic signed [DIN1_WIDTH:0]   din1_ext;
  logic signed [PROD_W-1:0]     prod_d;
  logic signed [PROD_W-1:0]     narrow_in;
  logic [DOUT_WIDTH-1:0]        dout_d;
  logic [DOUT_WIDTH-1:0]        dout_q;

  // Whole pipe moves as one; a held result at the tail freezes every stage.
  assign advance       = ce_i & (~v_q[NUM_STAGE-1] | bus.out_ready);
  assign bus.in_ready  = advance;
  assign bus.out_valid = v_q[NUM_STAGE-1];
  assign bus.dout      = dout_q;

  assign din1_ext = (DIN1_SIGNED != 0) ? {din1_q[DIN1_WIDTH-1], din1_q} : {1'b0, din1_q};
  assign prod_d   = PROD_W'(din0_q) * PROD_W'(din1_ext);

  generate
    if (NUM_STAGE == 2) begin : g_direct
      assign narrow_in = prod_d;
    end else begin : g_retime
      logic signed [PROD_W-1:0] prod_q [NUM_STAGE-2];

      always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
          for (int s = 0; s < NUM_STAGE-2; s++) prod_q[s] <= '0;
        end else if (advance) begin
          prod_q[0] <= prod_d;
          for (int s = 1; s < NUM_STAGE-2; s++) prod_q[s] <= prod_q[s-1];
        end
      end

      assign narrow_in = prod_q[NUM_STAGE-3];
    end
  endgenerate

  solve_ntru_mul_pipe_param_narrow #(
    .PROD_W     (PROD_W),
    .DOUT_WIDTH (DOUT_WIDTH),
    .SAT_MODE   (SAT_MODE)
  ) u_narrow (
    .prod_i (narrow_in),
    .dout_o (dout_d)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      v_q    <= '0;
      din0_q <= '0;
      din1_q <= '0;
      dout_q <= '0;
    end else if (advance) begin
      v_q    <= {v_q[NUM_STAGE-2:0], bus.in_valid};
      din0_q <= bus.din0;
      din1_q <= bus.din1;
      dout_q <= dout_d;
    end
  end

endmodule
